plic_gateway: RTL and testbench
===============================

Name: plic_gateway

Overview:
- Source-side end of the PLIC request/claim/complete protocol.
- Converts raw device interrupt lines (UART1, SPI, GPIO, ...) into per-source pending requests for the PLIC core.
- Tracks claim and complete for each source, so a source is never re-presented while a hart is servicing it.
- Sits between SoC peripheral IRQ wires and the PLIC priority/arbitration logic; one instance serves all sources.

Parameters:
- async_reset, CFG_ASYNC_RESET, selects asynchronous reset branch in register process
- irqmax, CFG_PLIC_IRQ_TOTAL (73), number of sources including hardwired source 0
- cntbits, 4, width of per-source edge counter (saturates at 2^cntbits-1)

Ports:
- i_clk  in  1  system clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_irq  in  irqmax  raw interrupt lines, synchronous to i_clk; bit 0 ignored
- i_edge_mode  in  irqmax  1=rising-edge triggered, 0=level-high triggered, per source
- i_claim_valid  in  1  PLIC core claims source i_claim_id this cycle
- i_claim_id  in  10  claimed source index
- i_complete_valid  in  1  hart wrote complete for i_complete_id
- i_complete_id  in  10  completed source index
- o_pending  out  irqmax  request to PLIC core; bit 0 always 0
- o_inflight  out  irqmax  source claimed, complete not yet received

Behaviour:
- Reset: all sources IDLE, edge counters 0, irq_prev 0, o_pending=0, o_inflight=0.
- Per-source state machine with states IDLE, PEND and INFLIGHT:
  - o_pending[k] is 1 only in PEND.
  - o_inflight[k] is 1 only in INFLIGHT.
- Edge detect: rise[k] = i_irq[k] & ~irq_prev[k], where irq_prev is registered every cycle.
- Edge mode:
  - Any rise increments cnt[k]; the counter saturates at 2^cntbits-1 and never wraps.
  - IDLE with cnt>0 or a rise this cycle goes to PEND; one count is consumed, so net cnt = cnt + rise - 1.
- Level mode:
  - cnt is held at 0.
  - IDLE with i_irq[k]=1 goes to PEND.
  - PEND stays PEND even if i_irq drops; the request is latched until claimed.
- Latency: i_irq[k] sampled high (edge or level) at clock edge N gives o_pending[k]=1 after edge N, i.e. one cycle.
- Claim:
  - With i_claim_valid and id=k and state PEND, the source goes to INFLIGHT at the next edge.
  - The claim is ignored if the state is not PEND, if id=0, or if id>=irqmax.
- Complete:
  - With i_complete_valid and id=k and state INFLIGHT, the source leaves INFLIGHT at the next edge.
  - Edge mode: go to PEND if cnt>0 or a rise occurs in the same cycle (consume one count), else IDLE.
  - Level mode: go to PEND if i_irq[k]=1, else IDLE.
  - The complete is ignored if the state is not INFLIGHT, if id=0, or if id>=irqmax.
- Edges arriving in PEND or INFLIGHT are counted (edge mode) and are not lost, up to saturation.
- Claim and complete in the same cycle on different ids: both processed independently.
- Claim and complete in the same cycle on the same id: at most one can match the current state, so only that one applies.
- Mode change:
  - A 1→0 change of i_edge_mode[k] clears cnt[k] at the next edge.
  - The current state is kept; the next transition uses the new mode.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous); pending and inflight requests are dropped.
- o_pending and o_inflight are registered outputs with no combinational path from inputs.

Decomposition:
- Add to the SoC package:
  - typedef plic_gw_state_type enum {IDLE, PEND, INFLIGHT}
  - constant CFG_PLIC_GW_CNTBITS=4
  - constant CFG_PLIC_ID_WIDTH=10 (covers the 1024-source maximum)
- Sub-module plic_gateway_src:
  - one source: state, cnt, irq_prev, claim/complete id compare
  - instantiated by generate for k=1..irqmax-1
  - top drives bit 0 to 0 and fans out the claim/complete buses

Test Plan:
- Level: src 11 (UART1) i_irq held 1, edge_mode=0 → o_pending[11]=1 one cycle later; claim id 11 → o_inflight[11]=1, o_pending[11]=0; complete with i_irq still 1 → o_pending[11]=1 the next cycle.
- Edge burst: src 12 edge_mode=1, 3 one-cycle pulses while INFLIGHT → each of three successive completes re-pends; the fourth complete → IDLE, cnt=0.
- Saturation: 20 pulses on src 5 with cntbits=4 while INFLIGHT → cnt=15; exactly 15 further claim/complete cycles pend, then IDLE.
- Invalid ids: claim id 0, id 73 and id 900; complete of an IDLE source → no state change in any source; o_pending[0] stays 0.
- Simultaneous: claim id 3 (PEND) and complete id 7 (INFLIGHT) in the same cycle, plus a rise on 7 → 3 INFLIGHT, 7 PEND with cnt unchanged.
- Reset mid-flight: sources 2 PEND and 9 INFLIGHT with cnt=4, pulse i_nrst low mid-cycle → o_pending=0 and o_inflight=0 immediately, and after release.

Source files
------------

// File: rtl/plic_gateway_pkg.sv
// Shared types and constants for the PLIC source gateway.
// Provides the per-source state encoding and the claim/complete id match helper.
package plic_gateway_pkg;

    localparam int CFG_PLIC_IRQ_TOTAL  = 73;
    localparam int CFG_PLIC_GW_CNTBITS = 4;
    localparam int CFG_PLIC_ID_WIDTH   = 10;
    localparam bit CFG_ASYNC_RESET     = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        INFLIGHT = 2'd2
    } plic_gw_state_type;

    // True when a valid claim/complete strobe addresses this source index.
    function automatic logic id_hit(input logic                         valid,
                                    input logic [CFG_PLIC_ID_WIDTH-1:0] id,
                                    input int unsigned                  src);
        logic [31:0] src_v;
        src_v = src;
        return valid && (id == src_v[CFG_PLIC_ID_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/plic_gateway_if.sv
// Bundle between the PLIC core side and the gateway: raw irq lines, modes,
// claim/complete strobes in, pending/inflight vectors out.
interface plic_gateway_if
    import plic_gateway_pkg::*;
#(
    parameter int irqmax = CFG_PLIC_IRQ_TOTAL,
    parameter int idw    = CFG_PLIC_ID_WIDTH
) ();

    logic [irqmax-1:0] i_irq;
    logic [irqmax-1:0] i_edge_mode;
    logic              i_claim_valid;
    logic [idw-1:0]    i_claim_id;
    logic              i_complete_valid;
    logic [idw-1:0]    i_complete_id;
    logic [irqmax-1:0] o_pending;
    logic [irqmax-1:0] o_inflight;

    modport master (
        output i_irq, i_edge_mode, i_claim_valid, i_claim_id,
               i_complete_valid, i_complete_id,
        input  o_pending, o_inflight
    );

    modport slave (
        input  i_irq, i_edge_mode, i_claim_valid, i_claim_id,
               i_complete_valid, i_complete_id,
        output o_pending, o_inflight
    );

endinterface

// File: rtl/plic_gateway_src.sv
// One interrupt source: edge/level qualification, saturating edge counter and
// the IDLE/PEND/INFLIGHT handshake with the PLIC core.
module plic_gateway_src
    import plic_gateway_pkg::*;
#(
    parameter int unsigned src_id      = 1,
    parameter int          cntbits     = CFG_PLIC_GW_CNTBITS,
    parameter bit          async_reset = CFG_ASYNC_RESET
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_irq,
    input  logic                         i_edge_mode,
    input  logic                         i_claim_valid,
    input  logic [CFG_PLIC_ID_WIDTH-1:0] i_claim_id,
    input  logic                         i_complete_valid,
    input  logic [CFG_PLIC_ID_WIDTH-1:0] i_complete_id,
    output logic                         o_pending,
    output logic                         o_inflight
);

    localparam logic [cntbits-1:0] CNT_MAX  = {cntbits{1'b1}};
    localparam logic [cntbits-1:0] CNT_ZERO = {cntbits{1'b0}};
    localparam logic [cntbits-1:0] CNT_ONE  = {{(cntbits-1){1'b0}}, 1'b1};

    plic_gw_state_type  state_r;
    plic_gw_state_type  state_nxt_s;
    logic [cntbits-1:0] cnt_r;
    logic [cntbits-1:0] cnt_nxt_s;
    logic [cntbits:0]   cnt_sum_s;
    logic               irq_prev_r;
    logic               pending_r;
    logic               inflight_r;
    logic               rise_s;
    logic               req_s;
    logic               take_s;
    logic               claim_hit_s;
    logic               complete_hit_s;

    // Qualify the raw line: a new request exists if a rise is seen now or
    // edges are banked (edge mode), or the line is high (level mode).
    always_comb begin
        rise_s         = i_irq & ~irq_prev_r;
        cnt_sum_s      = {1'b0, cnt_r} + {{cntbits{1'b0}}, rise_s};
        claim_hit_s    = id_hit(i_claim_valid, i_claim_id, src_id);
        complete_hit_s = id_hit(i_complete_valid, i_complete_id, src_id);
        if (i_edge_mode) begin
            req_s = (cnt_sum_s != {(cntbits+1){1'b0}});
        end else begin
            req_s = i_irq;
        end
    end

    // Next-state logic; take_s marks a transition into PEND that uses one request.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nxt_s = PEND;
                    take_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PEND: begin
                if (claim_hit_s) begin
                    state_nxt_s = INFLIGHT;
                end else begin
                    state_nxt_s = PEND;
                end
            end
            INFLIGHT: begin
                if (complete_hit_s && req_s) begin
                    state_nxt_s = PEND;
                    take_s      = 1'b1;
                end else if (complete_hit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = INFLIGHT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Edge bank: level mode pins it at zero; a consumed request nets cnt+rise-1,
    // which always fits, so modular arithmetic in cntbits is exact there.
    always_comb begin
        if (!i_edge_mode) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (take_s) begin
            cnt_nxt_s = cnt_r + {{(cntbits-1){1'b0}}, rise_s} - CNT_ONE;
        end else if (cnt_sum_s[cntbits]) begin
            cnt_nxt_s = CNT_MAX;
        end else begin
            cnt_nxt_s = cnt_sum_s[cntbits-1:0];
        end
    end

    generate
        if (async_reset) begin : g_async
            // State, counter, edge history and registered outputs, async clear.
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    state_r    <= IDLE;
                    cnt_r      <= CNT_ZERO;
                    irq_prev_r <= 1'b0;
                    pending_r  <= 1'b0;
                    inflight_r <= 1'b0;
                end else begin
                    state_r    <= state_nxt_s;
                    cnt_r      <= cnt_nxt_s;
                    irq_prev_r <= i_irq;
                    pending_r  <= (state_nxt_s == PEND);
                    inflight_r <= (state_nxt_s == INFLIGHT);
                end
            end
        end else begin : g_sync
            // Same register set with a clock-qualified clear.
            always_ff @(posedge i_clk) begin
                if (!i_nrst) begin
                    state_r    <= IDLE;
                    cnt_r      <= CNT_ZERO;
                    irq_prev_r <= 1'b0;
                    pending_r  <= 1'b0;
                    inflight_r <= 1'b0;
                end else begin
                    state_r    <= state_nxt_s;
                    cnt_r      <= cnt_nxt_s;
                    irq_prev_r <= i_irq;
                    pending_r  <= (state_nxt_s == PEND);
                    inflight_r <= (state_nxt_s == INFLIGHT);
                end
            end
        end
    endgenerate

    assign o_pending  = pending_r;
    assign o_inflight = inflight_r;

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway top: one source slice per interrupt 1..irqmax-1 sharing the
// claim/complete buses; source 0 is hardwired inactive.
module plic_gateway
    import plic_gateway_pkg::*;
#(
    parameter bit async_reset = CFG_ASYNC_RESET,
    parameter int irqmax      = CFG_PLIC_IRQ_TOTAL,
    parameter int cntbits     = CFG_PLIC_GW_CNTBITS
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    plic_gateway_if.slave  gw
);

    logic [irqmax-1:0] pending_s;
    logic [irqmax-1:0] inflight_s;
    logic              unused_s;

    assign pending_s[0]  = 1'b0;
    assign inflight_s[0] = 1'b0;
    assign unused_s      = ^{gw.i_irq[0], gw.i_edge_mode[0]};

    generate
        for (genvar k = 1; k < irqmax; k++) begin : g_src
            plic_gateway_src #(
                .src_id      (k),
                .cntbits     (cntbits),
                .async_reset (async_reset)
            ) u_src (
                .i_clk            (i_clk),
                .i_nrst           (i_nrst),
                .i_irq            (gw.i_irq[k]),
                .i_edge_mode      (gw.i_edge_mode[k]),
                .i_claim_valid    (gw.i_claim_valid),
                .i_claim_id       (gw.i_claim_id),
                .i_complete_valid (gw.i_complete_valid),
                .i_complete_id    (gw.i_complete_id),
                .o_pending        (pending_s[k]),
                .o_inflight       (inflight_s[k])
            );
        end
    endgenerate

    assign gw.o_pending  = pending_s;
    assign gw.o_inflight = inflight_s;

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboard bench for plic_gateway: directed scenarios plus random traffic,
// expectations from a behavioural per-source model.
module tb_plic_gateway;

    localparam int IRQ    = 73;
    localparam int IDW    = 10;
    localparam int CNTB   = 4;
    localparam int CNTMAX = 15;

    typedef struct {
        int               cyc;
        logic [IRQ-1:0]   pend;
        logic [IRQ-1:0]   infl;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    plic_gateway_if #(.irqmax(IRQ), .idw(IDW)) bus ();

    plic_gateway #(.async_reset(1'b1), .irqmax(IRQ), .cntbits(CNTB)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .gw     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [IRQ-1:0] irq_v, mode_v;
    logic           cv, pv;
    logic [IDW-1:0] cid, pid;
    string          phase = "reset";

    bit pend_m[IRQ];
    bit infl_m[IRQ];
    bit prev_m[IRQ];
    int cnt_m[IRQ];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose clock edge has already happened.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (bus.o_pending !== mon_e.pend || bus.o_inflight !== mon_e.infl) begin
                errors++;
                $display("FAIL %s: pending=%h inflight=%h required pending=%h inflight=%h",
                         mon_e.tag, bus.o_pending, bus.o_inflight, mon_e.pend, mon_e.infl);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < IRQ; k++) begin
            pend_m[k] = 1'b0; infl_m[k] = 1'b0; prev_m[k] = 1'b0; cnt_m[k] = 0;
        end
    endtask

    task automatic apply_inputs();
        bus.i_irq            = irq_v;
        bus.i_edge_mode      = mode_v;
        bus.i_claim_valid    = cv;
        bus.i_claim_id       = cid;
        bus.i_complete_valid = pv;
        bus.i_complete_id    = pid;
    endtask

    // One clock: drive inputs, advance the model, queue the post-edge outputs.
    task automatic tick();
        exp_t e;
        int   avail;
        bit   rise, want, take;
        apply_inputs();
        for (int k = 1; k < IRQ; k++) begin
            rise  = irq_v[k] && !prev_m[k];
            avail = cnt_m[k] + (rise ? 1 : 0);
            want  = mode_v[k] ? (avail > 0) : irq_v[k];
            take  = 1'b0;
            if (infl_m[k]) begin
                if (pv && int'(pid) == k) begin
                    infl_m[k] = 1'b0;
                    if (want) begin pend_m[k] = 1'b1; take = 1'b1; end
                end
            end else if (pend_m[k]) begin
                if (cv && int'(cid) == k) begin pend_m[k] = 1'b0; infl_m[k] = 1'b1; end
            end else if (want) begin
                pend_m[k] = 1'b1; take = 1'b1;
            end
            if (!mode_v[k])  cnt_m[k] = 0;
            else if (take)   cnt_m[k] = avail - 1;
            else             cnt_m[k] = (avail > CNTMAX) ? CNTMAX : avail;
            prev_m[k] = irq_v[k];
        end
        e.cyc = cyc + 1;
        e.tag = phase;
        for (int k = 0; k < IRQ; k++) begin
            e.pend[k] = pend_m[k];
            e.infl[k] = infl_m[k];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic claim(input int id);
        logic [31:0] v; v = id;
        cv = 1'b1; cid = v[IDW-1:0]; tick(); cv = 1'b0;
    endtask

    task automatic complete(input int id);
        logic [31:0] v; v = id;
        pv = 1'b1; pid = v[IDW-1:0]; tick(); pv = 1'b0;
    endtask

    task automatic pulse(input int k);
        irq_v[k] = 1'b1; tick(); irq_v[k] = 1'b0; tick();
    endtask

    // Pull reset low between edges, check outputs drop at once and stay low.
    task automatic reset_pulse();
        exp_t e;
        @(negedge clk);
        #1;
        nrst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.o_pending !== '0 || bus.o_inflight !== '0) begin
            errors++;
            $display("FAIL reset_immediate: pending=%h inflight=%h required all zero",
                     bus.o_pending, bus.o_inflight);
        end
        e.cyc = cyc; e.pend = '0; e.infl = '0; e.tag = "reset_held";
        sb_q.push_back(e);
        @(negedge clk);
        #2;
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_id(input bit want_pend);
        int start;
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 1023));
        start = int'($urandom_range(1, IRQ - 1));
        for (int n = 0; n < IRQ - 1; n++) begin
            int k;
            k = 1 + ((start - 1 + n) % (IRQ - 1));
            if (want_pend ? pend_m[k] : infl_m[k]) return k;
        end
        return int'($urandom_range(0, IRQ - 1));
    endfunction

    initial begin
        irq_v = '0; mode_v = '0; cv = 1'b0; pv = 1'b0; cid = '0; pid = '0;
        nrst  = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        phase = "level11";
        mode_v[11] = 1'b0; irq_v[11] = 1'b1; tick();
        claim(11);
        complete(11);
        claim(11);
        irq_v[11] = 1'b0;
        complete(11);
        tick();

        phase = "edge12";
        mode_v[12] = 1'b1; tick();
        pulse(12);
        claim(12);
        repeat (3) pulse(12);
        repeat (3) begin complete(12); claim(12); end
        complete(12);
        tick();

        phase = "sat5";
        mode_v[5] = 1'b1; tick();
        pulse(5);
        claim(5);
        repeat (20) pulse(5);
        repeat (15) begin complete(5); claim(5); end
        complete(5);
        tick();

        phase = "invalid";
        mode_v[20] = 1'b0; irq_v[20] = 1'b1; tick();
        irq_v[0] = 1'b1; mode_v[0] = 1'b1; tick();
        irq_v[0] = 1'b0; tick();
        claim(0); claim(73); claim(900);
        complete(30); complete(20);
        irq_v[20] = 1'b0;
        claim(20); complete(20);
        tick();

        phase = "simul";
        mode_v[3] = 1'b0; irq_v[3] = 1'b1; tick(); irq_v[3] = 1'b0;
        mode_v[7] = 1'b1; pulse(7); claim(7);
        irq_v[7] = 1'b1; cv = 1'b1; cid = 10'd3; pv = 1'b1; pid = 10'd7; tick();
        cv = 1'b0; pv = 1'b0; irq_v[7] = 1'b0; tick();
        claim(7); complete(7); tick();
        complete(3); tick();

        phase = "reset_mid";
        mode_v[2] = 1'b1; pulse(2);
        mode_v[9] = 1'b1; pulse(9); claim(9);
        repeat (4) pulse(9);
        reset_pulse();
        phase = "after_reset";
        repeat (3) tick();

        phase = "random";
        for (int k = 0; k < IRQ; k++) mode_v[k] = ($urandom_range(0, 1) == 1);
        irq_v = '0;
        for (int n = 0; n < 3000; n++) begin
            int k;
            if ($urandom_range(0, 1) == 0) begin
                k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, IRQ - 1))
                                                : int'($urandom_range(0, 12));
                irq_v[k] = ~irq_v[k];
            end
            if ($urandom_range(0, 49) == 0) begin
                k = int'($urandom_range(0, 12));
                mode_v[k] = ~mode_v[k];
            end
            if ($urandom_range(0, 2) == 0) begin
                k = pick_id(1'b1); cv = 1'b1; cid = k[IDW-1:0];
            end else begin
                cv = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                k = pick_id(1'b0); pv = 1'b1; pid = k[IDW-1:0];
            end else begin
                pv = 1'b0;
            end
            tick();
        end
        cv = 1'b0; pv = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
